// File: rtl/cdm_err_stats.sv
// cdm_err_stats
// Error-statistics collector for an approximate multiplier under test.
// A run is launched with a one-cycle start carrying n_samples; the block
// then accepts exactly n_samples (A, B, R) triples over a valid/ready
// handshake. Each triple is compared against the exact product A*B, and the
// run-level statistics are accumulated.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, n_samples  run request (ignored while busy) and sample count
//   in_valid/in_ready sample handshake, transfer when both are high
//   A, B, R           operands and approximate product
//   busy              high while a run is accepting or draining
//   done              one-cycle pulse once the statistics are final
//   err_count         number of samples with R != A*B
//   sum_ed            sum of |A*B - R|
//   max_ed            largest error distance, with operands max_a/max_b
module cdm_err_stats #(
  parameter int W     = 16,
  parameter int CNT_W = 20,
  parameter int ACC_W = 52
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [2*W-1:0]   R,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [2*W-1:0]   max_ed,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  function automatic logic [2*W-1:0] umul(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Absolute distance; the approximate product may over- or under-estimate.
  function automatic logic [2*W-1:0] err_dist(input logic [2*W-1:0] exact,
                                              input logic [2*W-1:0] approx);
    if (approx > exact) return approx - exact;
    else                return exact - approx;
  endfunction

  // The accumulator is wide enough for a full run of maximum errors, so a
  // plain zero-extended add never wraps.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [2*W-1:0]   ed);
    return acc + {{(ACC_W-2*W){1'b0}}, ed};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [2*W-1:0]   max_ed_q, max_ed_d;
  logic [W-1:0]     max_a_q, max_a_d;
  logic [W-1:0]     max_b_q, max_b_d;

  logic             vld_p0, vld_p1, vld_p2;
  logic             last_p0, last_p1, last_p2;
  logic [W-1:0]     a_p0, a_p1, a_p2;
  logic [W-1:0]     b_p0, b_p1, b_p2;
  logic [2*W-1:0]   r_p0, r_p1;
  logic [2*W-1:0]   exact_p1;
  logic [2*W-1:0]   ed_p2;
  logic             mis_p2;

  logic             xfer, is_last, start_acc, start_go, start_zero, commit_last;

  assign xfer        = in_valid & in_ready;
  assign is_last     = (rem_q == CNT_W'(1));
  assign start_acc   = (state_q == S_IDLE) & start;
  assign start_go    = start_acc & (n_samples != '0);
  assign start_zero  = start_acc & (n_samples == '0);
  assign commit_last = vld_p2 & last_p2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_RUN;
      S_RUN:   if (xfer && is_last) state_d = S_DRAIN;
      S_DRAIN: if (commit_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q != S_IDLE);
  end

  // Remaining-sample counter and statistics next state
  always_comb begin
    rem_d    = rem_q;
    err_d    = err_q;
    sum_d    = sum_q;
    max_ed_d = max_ed_q;
    max_a_d  = max_a_q;
    max_b_d  = max_b_q;
    done_d   = commit_last | start_zero;
    if (start_go) rem_d = n_samples;
    else if (xfer) rem_d = rem_q - CNT_W'(1);
    if (start_acc) begin
      err_d    = '0;
      sum_d    = '0;
      max_ed_d = '0;
      max_a_d  = '0;
      max_b_d  = '0;
    end else if (vld_p2) begin
      err_d = err_q + CNT_W'(mis_p2);
      sum_d = acc_add(sum_q, ed_p2);
      // Strictly greater: ties keep the earliest sample's operands.
      if (ed_p2 > max_ed_q) begin
        max_ed_d = ed_p2;
        max_a_d  = a_p2;
        max_b_d  = b_p2;
      end
    end
  end

  // Control registers: counter, done, statistics, pipeline valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= '0;
      sum_q    <= '0;
      max_ed_q <= '0;
      max_a_q  <= '0;
      max_b_q  <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      last_p0  <= 1'b0;
      last_p1  <= 1'b0;
      last_p2  <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      max_ed_q <= max_ed_d;
      max_a_q  <= max_a_d;
      max_b_q  <= max_b_d;
      vld_p0   <= xfer;
      last_p0  <= xfer & is_last;
      vld_p1   <= vld_p0;
      last_p1  <= last_p0;
      vld_p2   <= vld_p1;
      last_p2  <= last_p1;
    end
  end

  // Datapath: p0 captures the sample, p1 holds the exact product,
  // p2 holds the error distance; the statistics commit after p2.
  always_ff @(posedge clk) begin
    a_p0     <= A;
    b_p0     <= B;
    r_p0     <= R;
    exact_p1 <= umul(a_p0, b_p0);
    r_p1     <= r_p0;
    a_p1     <= a_p0;
    b_p1     <= b_p0;
    ed_p2    <= err_dist(exact_p1, r_p1);
    mis_p2   <= (exact_p1 != r_p1);
    a_p2     <= a_p1;
    b_p2     <= b_p1;
  end

  assign done      = done_q;
  assign err_count = err_q;
  assign sum_ed    = sum_q;
  assign max_ed    = max_ed_q;
  assign max_a     = max_a_q;
  assign max_b     = max_b_q;

endmodule

// File: tb/tb_cdm_err_stats.sv
// Testbench for cdm_err_stats: directed scenarios plus randomized runs
// checked against an arithmetic reference model of the run statistics.
module tb_cdm_err_stats;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] n_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic [31:0] R;
  logic        busy, done;
  logic [19:0] err_count;
  logic [51:0] sum_ed;
  logic [31:0] max_ed;
  logic [15:0] max_a, max_b;

  cdm_err_stats #(.W(16), .CNT_W(20), .ACC_W(52)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .R(R),
    .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed),
    .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0]  av [64];
  logic [15:0]  bv [64];
  logic [31:0]  rv [64];
  logic [135:0] st;
  assign st = {err_count, sum_ed, max_ed, max_a, max_b};

  int           obs_lat, obs_dlen, obs_acc;
  logic         obs_rdy_after, obs_busy_end, obs_busy_run;
  logic [135:0] obs_st;

  // Expected run statistics straight from the definition of the metrics.
  function automatic logic [135:0] model(input int n);
    longint e, s, mx, d;
    logic [15:0] ma, mb;
    e = 0; s = 0; mx = 0; ma = '0; mb = '0;
    for (int i = 0; i < n; i++) begin
      d = longint'(av[i]) * longint'(bv[i]) - longint'(rv[i]);
      if (d < 0) d = -d;
      if (d != 0) e++;
      s += d;
      if (d > mx) begin mx = d; ma = av[i]; mb = bv[i]; end
    end
    return {e[19:0], s[51:0], mx[31:0], ma, mb};
  endfunction

  // Drives one run; mode 0 = valid every cycle, 1 = every other cycle,
  // 2 = random. Records observations for the calling test to compare.
  task automatic run_one(input int n, input int mode, input bit hold, input bit drain_start);
    int  cyc, last;
    bit  v;
    @(negedge clk); start = 1'b1; n_samples = 20'(n);
    @(negedge clk); start = 1'b0; obs_busy_run = busy;
    obs_acc = 0; cyc = 0; last = 0;
    while (obs_acc < n && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v; A = av[obs_acc]; B = bv[obs_acc]; R = rv[obs_acc];
      if (v && in_ready) begin obs_acc++; last = cyc; end
      @(negedge clk); cyc++;
    end
    in_valid = hold;
    obs_rdy_after = in_ready;
    obs_lat = -1; obs_dlen = 0; obs_st = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 && drain_start) begin start = 1'b1; n_samples = 20'd5; end
      if (i == 1) start = 1'b0;
      if (done) begin
        if (obs_lat < 0) begin obs_lat = cyc - last; obs_st = st; end
        obs_dlen++;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    obs_busy_end = busy;
  endtask

  task automatic test_reset;
    if ({busy, in_ready, done} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000", {busy, in_ready, done});
    end
    total++;
    if (st !== '0) begin
      bad++; $display("FAIL reset_stats: got %h want 0", st);
    end
    total++;
  endtask

  task automatic test_exact;
    for (int i = 0; i < 4; i++) begin
      av[i] = 16'($urandom); bv[i] = 16'($urandom);
      rv[i] = 32'(av[i]) * 32'(bv[i]);
    end
    run_one(4, 0, 1'b0, 1'b0);
    if (obs_busy_run !== 1'b1) begin bad++; $display("FAIL exact_busy: got %b want 1", obs_busy_run); end
    total++;
    if (obs_lat != 4) begin bad++; $display("FAIL exact_lat: got %0d want 4", obs_lat); end
    total++;
    if (obs_dlen != 1) begin bad++; $display("FAIL exact_done_len: got %0d want 1", obs_dlen); end
    total++;
    if (obs_st !== '0) begin bad++; $display("FAIL exact_stats: got %h want 0", obs_st); end
    total++;
  endtask

  task automatic test_directed;
    av[0] = 16'd3;   bv[0] = 16'd5;   rv[0] = 32'd14;
    av[1] = 16'd100; bv[1] = 16'd200; rv[1] = 32'd19990;
    run_one(2, 0, 1'b0, 1'b0);
    if (obs_st !== {20'd2, 52'd11, 32'd10, 16'd100, 16'd200}) begin
      bad++; $display("FAIL directed_stats: got %h want %h", obs_st, {20'd2, 52'd11, 32'd10, 16'd100, 16'd200});
    end
    total++;
    // Statistics stay put in IDLE after the run.
    if (st !== obs_st) begin bad++; $display("FAIL directed_hold: got %h want %h", st, obs_st); end
    total++;
  endtask

  task automatic test_zero;
    @(negedge clk); start = 1'b1; n_samples = 20'd0;
    @(negedge clk); start = 1'b0;
    if ({done, busy} !== 2'b10) begin bad++; $display("FAIL zero_pulse: got %b want 10", {done, busy}); end
    total++;
    if (st !== '0) begin bad++; $display("FAIL zero_stats: got %h want 0", st); end
    total++;
    @(negedge clk);
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_after: got %b want 00", {done, busy}); end
    total++;
  endtask

  task automatic test_overestimate;
    av[0] = 16'd2; bv[0] = 16'd2; rv[0] = 32'd7;
    run_one(1, 0, 1'b0, 1'b0);
    if (obs_st !== {20'd1, 52'd3, 32'd3, 16'd2, 16'd2}) begin
      bad++; $display("FAIL over_stats: got %h want %h", obs_st, {20'd1, 52'd3, 32'd3, 16'd2, 16'd2});
    end
    total++;
    av[0] = 16'hFFFF; bv[0] = 16'hFFFF; rv[0] = 32'd0;
    run_one(1, 0, 1'b0, 1'b0);
    if (obs_st !== {20'd1, 52'd4294836225, 32'd4294836225, 16'hFFFF, 16'hFFFF}) begin
      bad++; $display("FAIL maxop_stats: got %h want %h", obs_st,
                      {20'd1, 52'd4294836225, 32'd4294836225, 16'hFFFF, 16'hFFFF});
    end
    total++;
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 8; i++) begin
      av[i] = 16'($urandom_range(1, 60000)); bv[i] = 16'($urandom_range(1, 60000));
      rv[i] = 32'(av[i]) * 32'(bv[i]) + 32'(i + 1);
    end
    run_one(3, 1, 1'b1, 1'b1);
    if (obs_acc != 3) begin bad++; $display("FAIL gaps_accepted: got %0d want 3", obs_acc); end
    total++;
    if (obs_rdy_after !== 1'b0) begin bad++; $display("FAIL gaps_ready_low: got %b want 0", obs_rdy_after); end
    total++;
    if (obs_lat != 4 || obs_dlen != 1) begin
      bad++; $display("FAIL gaps_done: got lat=%0d len=%0d want lat=4 len=1", obs_lat, obs_dlen);
    end
    total++;
    if (obs_st !== model(3)) begin bad++; $display("FAIL gaps_stats: got %h want %h", obs_st, model(3)); end
    total++;
    if (obs_busy_end !== 1'b0) begin bad++; $display("FAIL gaps_drain_start: busy got %b want 0", obs_busy_end); end
    total++;
  endtask

  task automatic test_reset_midrun;
    int acc, cyc, seen;
    for (int i = 0; i < 8; i++) begin av[i] = 16'(i + 3); bv[i] = 16'd7; rv[i] = 32'd0; end
    @(negedge clk); start = 1'b1; n_samples = 20'd8;
    @(negedge clk); start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 50) begin
      in_valid = 1'b1; A = av[acc]; B = bv[acc]; R = rv[acc];
      if (in_ready) acc++;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (st !== '0) begin bad++; $display("FAIL midrst_stats: got %h want 0", st); end
    total++;
    if ({busy, in_ready, done} !== 3'b000) begin
      bad++; $display("FAIL midrst_ctrl: got %b want 000", {busy, in_ready, done});
    end
    total++;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    if (seen != 0) begin bad++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen); end
    total++;
    av[0] = 16'd10; bv[0] = 16'd10; rv[0] = 32'd90;
    run_one(1, 0, 1'b0, 1'b0);
    if (obs_lat != 4 || obs_st !== {20'd1, 52'd10, 32'd10, 16'd10, 16'd10}) begin
      bad++; $display("FAIL midrst_rerun: got lat=%0d stats=%h want lat=4 stats=%h", obs_lat, obs_st,
                      {20'd1, 52'd10, 32'd10, 16'd10, 16'd10});
    end
    total++;
  endtask

  task automatic test_random;
    int n;
    logic [31:0] ex;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 5) == 0) begin
          // Swapped operands of the previous sample give an equal error
          // distance, exercising the tie rule.
          av[i] = bv[i-1]; bv[i] = av[i-1]; rv[i] = rv[i-1];
        end else begin
          av[i] = 16'($urandom); bv[i] = 16'($urandom);
          ex = 32'(av[i]) * 32'(bv[i]);
          case ($urandom_range(0, 3))
            0:       rv[i] = ex;
            1:       rv[i] = ex + 32'($urandom_range(1, 500));
            2:       rv[i] = ex - 32'($urandom_range(1, 500));
            default: rv[i] = $urandom;
          endcase
        end
      end
      run_one(n, 2, 1'b0, 1'b0);
      if (obs_acc != n || obs_lat != 4 || obs_dlen != 1) begin
        bad++; $display("FAIL rand%0d_ctrl: got acc=%0d lat=%0d len=%0d want acc=%0d lat=4 len=1",
                        r, obs_acc, obs_lat, obs_dlen, n);
      end
      total++;
      if (obs_st !== model(n)) begin
        bad++; $display("FAIL rand%0d_stats: got %h want %h", r, obs_st, model(n));
      end
      total++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_samples = '0; in_valid = 1'b0;
    A = '0; B = '0; R = '0;
    @(negedge clk); @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_exact;
    test_directed;
    test_zero;
    test_overestimate;
    test_gaps;
    test_reset_midrun;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/cdm_err_stats.md
CDM_ERR_STATS -- requirements
Module: cdm_err_stats

Interface
REQ-001 Parameter W, default 16, operand width of the multiplier under test.
REQ-002 Parameter CNT_W, default 20, sample-counter width (max 1,048,575 samples per run).
REQ-003 Parameter ACC_W, default 52, error-sum accumulator width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle run request; latches n_samples.
REQ-007 n_samples  input  CNT_W  number of samples in the run.
REQ-008 in_valid  input  1  A/B/R presented this cycle.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 A, B  input  W each  multiplier operands.
REQ-011 R  input  2W  approximate product from the multiplier.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse at end of run.
REQ-014 err_count  output  CNT_W  samples with R != A*B.
REQ-015 sum_ed  output  ACC_W  sum of |A*B - R|.
REQ-016 max_ed  output  2W  largest error distance seen.
REQ-017 max_a, max_b  output  W each  operands producing max_ed.

Function
REQ-018 Transfer occurs on a rising edge where in_valid and in_ready are both high; no other edge consumes a sample.
REQ-019 States: IDLE, RUN, DRAIN; busy = (state != IDLE).
REQ-020 IDLE + start with n_samples > 0: clear all statistics, load remaining count = n_samples, go to RUN next edge.
REQ-021 IDLE + start with n_samples == 0: stay IDLE, statistics cleared, done pulses in the following cycle.
REQ-022 start while busy is ignored.
REQ-023 in_ready = 1 only in RUN, i.e. while fewer than n_samples have been accepted; it falls in the cycle after the last transfer.
REQ-024 RUN -> DRAIN on the edge accepting the last sample; DRAIN -> IDLE on the edge committing that sample's statistics.
REQ-025 Pipeline: edge k accepts sample; edge k+1 registers exact = A*B (unsigned, 2W bits) plus R, A and B; edge k+2 registers ed = |exact - R| (2W bits, correct for R > exact) and a mismatch flag; edge k+3 updates statistics.
REQ-026 Pipeline advances unconditionally; gaps in in_valid create bubbles that update nothing.
REQ-027 Per committed sample: err_count += (ed != 0); sum_ed += ed, zero-extended; no saturation needed since ACC_W >= 2W + CNT_W.
REQ-028 max update only when ed > max_ed strictly; ties keep the earlier sample's max_a/max_b.
REQ-029 done is asserted for exactly one cycle, in the cycle after the last sample's statistics commit; the values are final when done is high.
REQ-030 Statistics hold their values in IDLE until the next accepted start.

Reset
REQ-031 rst_n low immediately forces: state IDLE, in_ready 0, busy 0, done 0, all statistics 0, pipeline valids 0, counters 0.
REQ-032 Reset mid-run discards in-flight samples with no done pulse; the first start after release behaves as from power-up.

Verification
REQ-033 n=4, R = A*B exactly for all samples -> err_count 0, sum_ed 0, max_ed 0, done pulse 4 cycles after the last transfer.
REQ-034 n=2: (A=3, B=5, R=14), (A=100, B=200, R=19990) -> err_count 2, sum_ed 11, max_ed 10, max_a 100, max_b 200.
REQ-035 n=1: A=2, B=2, R=7 (overestimate) -> ed 3; A=65535, B=65535, R=0 -> max_ed 4294836225.
REQ-036 start with n=0 -> done high exactly one cycle, busy never high, statistics 0.
REQ-037 n=3 with in_valid toggling every other cycle and held high after the third transfer -> exactly 3 samples counted, in_ready 0 after the third transfer, start during DRAIN ignored.
REQ-038 n=8, rst_n pulsed low after 3 transfers -> all outputs 0 asynchronously and no done pulse; a new start with n=1 then completes correctly.
